add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
- Time-shares one N-bit lookAheadCarryAdder instance between NREQ independent requesters.
- Each requester presents operands with a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle. The sum is registered and returned on a shared response channel tagged with the requester ID.
- Sits between the ALU front-end issue logic and the shared add datapath.

Parameters:
- N, 32, operand/sum width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  input  NREQ*N  operand A, requester k at bits [k*N +: N].
- req_b  input  NREQ*N  operand B, same packing.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts response.
- rsp_sum  output  N  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_id  output  IDW  index of the requester that produced the result.
- busy_cnt  output  16  saturating count of cycles where any req_valid was high but no grant issued (back-pressure monitor).

Behaviour:
- Reset:
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy_cnt=0.
  - Round-robin pointer rr_ptr=0 (requester 0 has highest priority first).
  - req_ready=0 during the reset cycle.
- can_accept = !rsp_valid | rsp_ready. This is the single-entry output slot being empty or draining this cycle.
- Arbitration (combinational):
  - When can_accept, grant the first k with req_valid[k]=1, scanning from rr_ptr upward modulo NREQ.
  - req_ready[k]=1 only for the granted k. req_ready is all-zero when !can_accept or no request is valid.
- Transfer: occurs for requester k when req_valid[k] & req_ready[k].
  - Granted operands feed the adder combinationally.
  - On the clock edge: rsp_sum/rsp_cout <= adder outputs, rsp_id <= k, rsp_valid <= 1, rr_ptr <= (k+1) mod NREQ.
  - Latency: result visible one cycle after the handshake.
- Drain:
  - rsp_valid & rsp_ready with no new grant: rsp_valid <= 0; sum/cout/id hold their last values.
  - Drain and new grant in the same cycle: register reloads and rsp_valid stays 1 (full throughput, one add per cycle).
- Hold: rsp_valid & !rsp_ready keeps rsp_sum/rsp_cout/rsp_id stable and all req_ready=0.
- rr_ptr updates only on a transfer; it is unchanged on idle cycles.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin as unsigned (N+1)-bit.
  - Carry-out is reported, never dropped. Overflow interpretation belongs to the consumer.
- busy_cnt: increments when (|req_valid) & !(|req_ready). It saturates at 16'hFFFF and does not wrap.
- Requesters may deassert req_valid without a handshake; there is no sticky grant.
- Reset mid-operation: an in-flight response is discarded (rsp_valid=0 next cycle), with no partial state retained.
- Unused ID values (k >= NREQ) are never produced.

Decomposition:
- Shared package add_share_pkg holds:
  - localparam defaults for N/NREQ/IDW;
  - function rr_pick(valid_vec, ptr) returning the grant index and a found flag.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector, enable, advance; outputs one-hot grant and encoded index; owns rr_ptr.
- The adder is the existing lookAheadCarryAdder, instantiated once with c_in from the muxed requester.

Test Plan:
- Reset: hold rst_n=0 two cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, busy_cnt=0. First grant after release goes to requester 0.
- Single add: requester 2 drives a=32'hFFFF_FFFF, b=32'h1, cin=0, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0, rsp_cout=1, rsp_id=2.
- Round-robin fairness: all four req_valid held high for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3, one response per cycle, no gaps.
- Back-pressure:
  - Response pending with rsp_ready=0 for 3 cycles and req_valid[1]=1 -> req_ready=0, rsp_* stable, busy_cnt increments by 3.
  - rsp_ready=1 in the 4th cycle -> requester 1 granted in that same cycle.
- Carry-in path: requester 3 drives a=32'h7FFF_FFFF, b=0, cin=1 -> rsp_sum=32'h8000_0000, rsp_cout=0.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, rr_ptr back to 0. Also preload busy_cnt near saturation and confirm it stops at 16'hFFFF.

Source files
------------

// File: rtl/add_share_pkg.sv
// Shared defaults and the round-robin pick helper for the shared-adder arbiter.
package add_share_pkg;

    localparam int unsigned NDef    = 32;
    localparam int unsigned NreqDef = 4;
    localparam int unsigned IdwDef  = 2;
    localparam int unsigned MaxReq  = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid_vec scanning upward from ptr, wrapping at nreq.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid_vec,
                                         input int unsigned       ptr,
                                         input int unsigned       nreq);
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < nreq) begin
                k = (ptr + i) % nreq;
                if (!res.found && valid_vec[k[2:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[2:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lookAheadCarryAdder.sv
// N-bit adder built from per-bit generate/propagate terms with carry-in and carry-out.
module lookAheadCarryAdder #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N-1:0] g;
    logic [N-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : carry_chain
        logic [N:0] c;
        c    = '0;
        c[0] = c_in;
        for (int unsigned i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum   = p ^ c[N-1:0];
        c_out = c[N];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer, which only moves on an accepted grant.
module rr_arbiter
    import add_share_pkg::*;
#(
    parameter int unsigned NREQ = NreqDef,
    parameter int unsigned IDW  = IdwDef
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic            adv_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            found_o
);

    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [MaxReq-1:0] req_ext;
    rr_pick_t          pick;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req_i;
        pick               = rr_pick(req_ext, 32'(ptr_q), NREQ);
    end

    assign found_o = en_i & pick.found;
    assign idx_o   = IDW'(pick.idx);

    always_comb begin
        gnt_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            gnt_o[k] = found_o && (pick.idx == 3'(k));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = IDW'((32'(pick.idx) + 32'd1) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Time-shares one adder across NREQ requesters; registered, ID-tagged single-slot response.
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int unsigned N    = NDef,
    parameter int unsigned NREQ = NreqDef,
    parameter int unsigned IDW  = IdwDef
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       busy_cnt
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     busy_q, busy_d;

    logic            can_accept;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_found;
    logic            xfer;
    logic [N-1:0]    a_mux, b_mux, add_sum;
    logic            cin_mux, add_cout;

    // Grants are suppressed while in reset so no requester sees a phantom accept.
    assign can_accept = (!rsp_valid_q || rsp_ready) && rst_n;
    assign xfer       = |(req_valid & gnt);
    assign req_ready  = gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_valid),
        .en_i    (can_accept),
        .adv_i   (xfer),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .found_o (gnt_found)
    );

    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        cin_mux = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                a_mux   = req_a[k*N +: N];
                b_mux   = req_b[k*N +: N];
                cin_mux = req_cin[k];
            end
        end
    end

    lookAheadCarryAdder #(
        .N (N)
    ) u_add (
        .a     (a_mux),
        .b     (b_mux),
        .c_in  (cin_mux),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        busy_d      = busy_q;
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_cout_d  = add_cout;
            rsp_id_d    = gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if ((|req_valid) && !gnt_found && (busy_q != 16'hFFFF)) begin
            busy_d = busy_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
            busy_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: behavioural model checked every cycle plus directed literal checks.
module tb_add_share_arbiter;

    localparam int unsigned N    = 32;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       busy_cnt;

    int tests = 0;
    int fails = 0;

    add_share_arbiter #(
        .N    (N),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: single response slot, rotating priority pointer, stall counter.
    int          m_ptr   = 0;
    bit          m_valid = 0;
    logic [32:0] m_res   = '0;
    int          m_id    = 0;
    int          m_busy  = 0;
    bit          m_init  = 0;

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = exp_grant();
        m_init <= 1'b1;
        if (!rst_n) begin
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_res   <= '0;
            m_id    <= 0;
            m_busy  <= 0;
        end else begin
            if (g >= 0) begin
                m_res   <= {1'b0, req_a[g*N +: N]} + {1'b0, req_b[g*N +: N]} + 33'(req_cin[g]);
                m_id    <= g;
                m_valid <= 1'b1;
                m_ptr   <= (g + 1) % NREQ;
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
            if ((|req_valid) && g < 0 && m_busy < 65535) m_busy <= m_busy + 1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            int          g;
            logic [3:0]  er;
            g  = exp_grant();
            er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            chk("model req_ready", 64'(req_ready), 64'(er));
            chk("model rsp_valid", 64'(rsp_valid), 64'(m_valid));
            chk("model rsp_sum",   64'(rsp_sum),   64'(m_res[31:0]));
            chk("model rsp_cout",  64'(rsp_cout),  64'(m_res[32]));
            chk("model rsp_id",    64'(rsp_id),    64'(m_id));
            chk("model busy_cnt",  64'(busy_cnt),  64'(m_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
        req_cin[k]      = cin;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;

        // Reset held two cycles with every requester valid
        tick();
        @(negedge clk);
        chk("reset req_ready c1", 64'(req_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("reset req_ready c2", 64'(req_ready), 64'h0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset busy_cnt", 64'(busy_cnt), 64'h0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("first grant req0", 64'(req_ready), 64'h1);

        // Fairness: 8 back-to-back grants in rotating order
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 7) req_valid = 4'h0;
            @(negedge clk);
            chk("rr rsp_id", 64'(rsp_id), 64'(j % 4));
            chk("rr rsp_valid", 64'(rsp_valid), 64'h1);
        end

        // Wrap-around with carry-out
        tick();
        set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single req_ready", 64'(req_ready), 64'h4);
        tick();
        set_req(3, 32'h7FFF_FFFF, 32'h0, 1'b1);
        req_valid = 4'b1000;
        @(negedge clk);
        chk("single rsp_sum", 64'(rsp_sum), 64'h0);
        chk("single rsp_cout", 64'(rsp_cout), 64'h1);
        chk("single rsp_id", 64'(rsp_id), 64'h2);

        // Carry-in path, then back-pressure with requester 1 waiting
        tick();
        set_req(1, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("cin rsp_sum", 64'(rsp_sum), 64'h8000_0000);
        chk("cin rsp_cout", 64'(rsp_cout), 64'h0);
        chk("cin rsp_id", 64'(rsp_id), 64'h3);
        chk("bp busy start", 64'(busy_cnt), 64'h0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            @(negedge clk);
            chk("bp busy_cnt", 64'(busy_cnt), 64'(i));
            chk("bp req_ready", 64'(req_ready), 64'h0);
            chk("bp rsp_sum hold", 64'(rsp_sum), 64'h8000_0000);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp busy 3", 64'(busy_cnt), 64'h3);
        chk("bp release grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        chk("bp rsp_id", 64'(rsp_id), 64'h1);
        chk("bp rsp_sum", 64'(rsp_sum), 64'd13);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst_n     = ($urandom_range(0, 63) != 0);
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_cin   = 4'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                case ($urandom_range(0, 4))
                    0:       set_req(k, 32'hFFFF_FFFF, 32'($urandom), req_cin[k]);
                    1:       set_req(k, 32'h0, 32'h0, req_cin[k]);
                    default: set_req(k, 32'($urandom), 32'($urandom), req_cin[k]);
                endcase
            end
        end

        // Reset while a response is stalled
        tick();
        rst_n     = 1'b1;
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst pending", 64'(rsp_valid), 64'h1);
        chk("midrst id", 64'(rsp_id), 64'h2);
        tick();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("midrst ready in reset", 64'(req_ready), 64'h0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("midrst ptr reset", 64'(req_ready), 64'h1);

        // Saturation of the stall counter
        tick();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        repeat (65540) tick();
        @(negedge clk);
        chk("busy saturate", 64'(busy_cnt), 64'hFFFF);
        tick();
        @(negedge clk);
        chk("busy no wrap", 64'(busy_cnt), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
